// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU execution sequencer: ALU opcodes and FSM state encoding.
package alu_seq_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the sequencer: two operand read ports, one debug read port,
// one synchronous write port; register 0 is hardwired to zero.
module alu_seq_regfile #(
    parameter int N  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    output logic [N-1:0]  rdata2,
    output logic [N-1:0]  rdata3,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd
);

    localparam int DEPTH = 2 ** AW;

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Address 0 is masked on every read port so r0 reads as zero regardless of storage.
    assign rdata2   = (ra2 == '0)      ? '0 : mem[ra2];
    assign rdata3   = (ra3 == '0)      ? '0 : mem[ra3];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_exec_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WB) sequencing a shared combinational ALU.
// Optional zero/carry flags are built when ALU_FLAGS_EN is defined.
module alu_exec_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs2,
    input  logic [AW-1:0] in_rs3,
    output logic [2:0]    alu_op,
    output logic [N-1:0]  alu_r2,
    output logic [N-1:0]  alu_r3,
    input  logic [N-1:0]  alu_r1,
    input  logic          alu_cout,
    input  logic          alu_cout2,
    output logic          done,
    output logic          illegal,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data,
    output logic          flag_z,
    output logic          flag_c
);

    seq_state_t state, state_nxt;

    logic [2:0]    op_r;
    logic [AW-1:0] rd_r, rs2_r, rs3_r;
    logic [N-1:0]  opnd2_r, opnd3_r, result_r;
    logic [N-1:0]  rf_rdata2, rf_rdata3;
    logic          rf_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (in_valid) state_nxt = S_READ;
            S_READ: state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_WB;
            S_WB:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are latched in READ, so an rd that aliases rs2/rs3 still sees old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= OP_MOV;
            rd_r     <= '0;
            rs2_r    <= '0;
            rs3_r    <= '0;
            opnd2_r  <= '0;
            opnd3_r  <= '0;
            result_r <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_r  <= in_op;
                    rd_r  <= in_rd;
                    rs2_r <= in_rs2;
                    rs3_r <= in_rs3;
                end
                S_READ: begin
                    opnd2_r <= rf_rdata2;
                    opnd3_r <= rf_rdata3;
                end
                S_EXEC:  result_r <= alu_r1;
                default: ;
            endcase
        end
    end

    assign rf_we    = (state == S_WB) && (op_r != OP_ILL);
    assign in_ready = (state == S_IDLE);
    assign done     = (state == S_WB);
    assign illegal  = (state == S_WB) && (op_r == OP_ILL);
    assign alu_op   = op_r;
    assign alu_r2   = opnd2_r;
    assign alu_r3   = opnd3_r;

    alu_seq_regfile #(.N(N), .AW(AW)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra2      (rs2_r),
        .ra3      (rs3_r),
        .rdata2   (rf_rdata2),
        .rdata3   (rf_rdata3),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (rd_r),
        .wd       (result_r)
    );

`ifdef ALU_FLAGS_EN
    logic cout_r, cout2_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_r  <= 1'b0;
            cout2_r <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            if (state == S_EXEC) begin
                cout_r  <= alu_cout;
                cout2_r <= alu_cout2;
            end
            // Flags only move on a legal retire; they hold across idle and illegal ops.
            if (rf_we) begin
                flag_z <= (result_r == '0);
                flag_c <= (op_r == OP_ADD) ? cout_r :
                          (op_r == OP_SUB) ? cout2_r : 1'b0;
            end
        end
    end
`else
    logic unused_carry;

    assign unused_carry = alu_cout ^ alu_cout2;
    assign flag_z       = 1'b0;
    assign flag_c       = 1'b0;
`endif

endmodule
